// File: rtl/gmii_udp_av_rx.sv
// GMII receiver: parses Ethernet/IPv4/UDP frames addressed to NCH consecutive IPs and
// demultiplexes the payload into a tagged pixel stream and an aux record stream.
module gmii_udp_av_rx #(
    parameter logic [31:0] IPV4_DST_BASE = 32'hC0A80001,
    parameter logic [15:0] DST_PORT      = 16'd12345,
    parameter int          NCH           = 2,
    parameter int          CHW           = 2,
    parameter int          PIX_BYTES     = 2,
    parameter int          VID_BYTES     = 1200,
    parameter int          AUX_REC_BYTES = 32
) (
    input  logic                         clk125,
    input  logic                         sys_rst_n,
    input  logic [7:0]                   rxd,
    input  logic                         rx_dv,
    input  logic                         rx_er,
    output logic [CHW+16+8*PIX_BYTES-1:0] vid_data,
    output logic                         vid_wr_en,
    output logic                         vid_sof,
    output logic                         vid_abort,
    output logic [23:0]                  aux_data,
    output logic                         aux_wr_en,
    output logic [15:0]                  pkt_ok_cnt,
    output logic [15:0]                  pkt_drop_cnt
);

    localparam int SRW = 8 * PIX_BYTES - 8;
    localparam int VCW = $clog2(VID_BYTES + 1);
    localparam int ACW = $clog2(AUX_REC_BYTES + 1);
    localparam logic [VCW-1:0] VID_LAST = VCW'(VID_BYTES - 1);
    localparam logic [ACW-1:0] AUX_LAST = ACW'(AUX_REC_BYTES - 1);
    localparam logic [1:0]     PIX_LAST = 2'(PIX_BYTES - 1);
    localparam logic [7:0]     NCH8     = 8'(NCH);
    localparam logic [7:0]     SFD      = 8'hD5;
    localparam logic [7:0]     PREAMBLE = 8'h55;

    typedef enum logic [2:0] {
        IDLE, PRE, HDR, INFO, VID, AUX_HDR, AUX_DAT, DROP
    } state_t;

    state_t           state;
    logic             dv_q;
    logic [5:0]       bidx;
    logic [CHW-1:0]   ch;
    logic [11:0]      y;
    logic [3:0]       x;
    logic             with_aux;
    logic             first;
    logic [VCW-1:0]   vcnt;
    logic [1:0]       pcnt;
    logic [SRW-1:0]   pix_sr;
    logic             ahb;
    logic [11:0]      id;
    logic [3:0]       left;
    logic [3:0]       rec_done;
    logic [ACW-1:0]   acnt;
    logic [7:0]       ch_diff;
    logic             in_pkt;
    logic             fin;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign ch_diff = rxd - IPV4_DST_BASE[7:0];
    assign in_pkt  = (state == INFO) || (state == VID) || (state == AUX_HDR) || (state == AUX_DAT);

    // fin marks the byte that completes a packet; an rx_er on that byte does not abort it
    always_comb begin
        fin = 1'b0;
        case (state)
            VID:     fin = (vcnt == VID_LAST) && !with_aux;
            AUX_HDR: fin = ahb && (rec_done == 4'd0) && (rxd[7:4] == 4'd0);
            AUX_DAT: fin = (acnt == AUX_LAST) && (4'(rec_done + 4'd1) == left);
            default: fin = 1'b0;
        endcase
    end

    always_ff @(posedge clk125 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state        <= IDLE;
            dv_q         <= 1'b1;
            bidx         <= '0;
            ch           <= '0;
            y            <= '0;
            x            <= '0;
            with_aux     <= 1'b0;
            first        <= 1'b0;
            vcnt         <= '0;
            pcnt         <= '0;
            pix_sr       <= '0;
            ahb          <= 1'b0;
            id           <= '0;
            left         <= '0;
            rec_done     <= '0;
            acnt         <= '0;
            vid_data     <= '0;
            vid_wr_en    <= 1'b0;
            vid_sof      <= 1'b0;
            vid_abort    <= 1'b0;
            aux_data     <= '0;
            aux_wr_en    <= 1'b0;
            pkt_ok_cnt   <= '0;
            pkt_drop_cnt <= '0;
        end else begin
            dv_q      <= rx_dv;
            vid_wr_en <= 1'b0;
            vid_sof   <= 1'b0;
            aux_wr_en <= 1'b0;
            vid_abort <= 1'b0;
            if (!rx_dv) begin
                if (in_pkt) begin
                    vid_abort    <= 1'b1;
                    pkt_drop_cnt <= sat_inc(pkt_drop_cnt);
                end
                state <= IDLE;
            end else if (rx_er && !fin) begin
                if (in_pkt) begin
                    vid_abort    <= 1'b1;
                    pkt_drop_cnt <= sat_inc(pkt_drop_cnt);
                end
                state <= DROP;
            end else begin
                case (state)
                    IDLE: begin
                        // dv_q gate keeps a frame cut by reset from being re-parsed mid-stream
                        if (!dv_q) begin
                            bidx <= '0;
                            if (rxd == SFD)           state <= HDR;
                            else if (rxd == PREAMBLE) state <= PRE;
                            else                      state <= DROP;
                        end
                    end
                    PRE: begin
                        bidx <= '0;
                        if (rxd == SFD)           state <= HDR;
                        else if (rxd != PREAMBLE) state <= DROP;
                    end
                    HDR: begin
                        bidx <= bidx + 6'd1;
                        case (bidx)
                            6'd12: if (rxd != 8'h08) state <= DROP;
                            6'd13: if (rxd != 8'h00) state <= DROP;
                            6'd14: if (rxd != 8'h45) state <= DROP;
                            6'd23: if (rxd != 8'h11) state <= DROP;
                            6'd30: if (rxd != IPV4_DST_BASE[31:24]) state <= DROP;
                            6'd31: if (rxd != IPV4_DST_BASE[23:16]) state <= DROP;
                            6'd32: if (rxd != IPV4_DST_BASE[15:8])  state <= DROP;
                            6'd33: begin
                                ch <= ch_diff[CHW-1:0];
                                if (ch_diff >= NCH8) state <= DROP;
                            end
                            6'd36: if (rxd != DST_PORT[15:8]) state <= DROP;
                            6'd37: if (rxd != DST_PORT[7:0])  state <= DROP;
                            6'd41: state <= INFO;
                            default: ;
                        endcase
                    end
                    INFO: begin
                        bidx <= bidx + 6'd1;
                        case (bidx)
                            6'd42: begin
                                with_aux <= (rxd == 8'h02);
                                if (rxd == 8'h01) begin
                                    state    <= AUX_HDR;
                                    ahb      <= 1'b0;
                                    rec_done <= '0;
                                end else if (rxd != 8'h00 && rxd != 8'h02) begin
                                    state        <= DROP;
                                    pkt_drop_cnt <= sat_inc(pkt_drop_cnt);
                                end
                            end
                            6'd43: y[7:0] <= rxd;
                            default: begin
                                x       <= rxd[7:4];
                                y[11:8] <= rxd[3:0];
                                state   <= VID;
                                vcnt    <= '0;
                                pcnt    <= '0;
                                first   <= 1'b1;
                            end
                        endcase
                    end
                    VID: begin
                        pix_sr <= SRW'({pix_sr, rxd});
                        vcnt   <= vcnt + VCW'(1);
                        if (pcnt == PIX_LAST) begin
                            pcnt      <= '0;
                            vid_wr_en <= 1'b1;
                            vid_sof   <= first;
                            first     <= 1'b0;
                            vid_data  <= {ch, y, x, pix_sr, rxd};
                        end else begin
                            pcnt <= pcnt + 2'd1;
                        end
                        if (vcnt == VID_LAST) begin
                            if (with_aux) begin
                                state    <= AUX_HDR;
                                ahb      <= 1'b0;
                                rec_done <= '0;
                            end else begin
                                pkt_ok_cnt <= sat_inc(pkt_ok_cnt);
                                state      <= DROP;
                            end
                        end
                    end
                    AUX_HDR: begin
                        if (!ahb) begin
                            id[7:0] <= rxd;
                            ahb     <= 1'b1;
                        end else begin
                            ahb      <= 1'b0;
                            id[11:8] <= rxd[3:0];
                            acnt     <= '0;
                            if (rec_done == 4'd0) left <= rxd[7:4];
                            if (rec_done == 4'd0 && rxd[7:4] == 4'd0) begin
                                pkt_ok_cnt <= sat_inc(pkt_ok_cnt);
                                state      <= DROP;
                            end else begin
                                state <= AUX_DAT;
                            end
                        end
                    end
                    AUX_DAT: begin
                        aux_data  <= {id, 4'h0, rxd};
                        aux_wr_en <= 1'b1;
                        acnt      <= acnt + ACW'(1);
                        if (acnt == AUX_LAST) begin
                            rec_done <= rec_done + 4'd1;
                            if (4'(rec_done + 4'd1) == left) begin
                                pkt_ok_cnt <= sat_inc(pkt_ok_cnt);
                                state      <= DROP;
                            end else begin
                                state <= AUX_HDR;
                            end
                        end
                    end
                    default: state <= DROP;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gmii_udp_av_rx.sv
// Scoreboard bench for gmii_udp_av_rx: directed frames push expected writes,
// a negedge monitor pops and compares every vid/aux write.
`timescale 1ns/1ps
module tb_gmii_udp_av_rx;

    logic        clk125 = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [7:0]  rxd = 8'h00;
    logic        rx_dv = 1'b0;
    logic        rx_er = 1'b0;
    logic [33:0] vid_data;
    logic        vid_wr_en, vid_sof, vid_abort, aux_wr_en;
    logic [23:0] aux_data;
    logic [15:0] pkt_ok_cnt, pkt_drop_cnt;

    gmii_udp_av_rx #(
        .IPV4_DST_BASE(32'hC0A80001),
        .DST_PORT(16'd12345),
        .NCH(2),
        .CHW(2),
        .PIX_BYTES(2),
        .VID_BYTES(1200),
        .AUX_REC_BYTES(32)
    ) dut (
        .clk125(clk125),
        .sys_rst_n(sys_rst_n),
        .rxd(rxd),
        .rx_dv(rx_dv),
        .rx_er(rx_er),
        .vid_data(vid_data),
        .vid_wr_en(vid_wr_en),
        .vid_sof(vid_sof),
        .vid_abort(vid_abort),
        .aux_data(aux_data),
        .aux_wr_en(aux_wr_en),
        .pkt_ok_cnt(pkt_ok_cnt),
        .pkt_drop_cnt(pkt_drop_cnt)
    );

    always #4 clk125 = ~clk125;

    int compared = 0;
    int mismatched = 0;
    int vid_seen = 0, aux_seen = 0, abort_seen = 0;
    int v0, a0, ab0;
    logic [34:0] exp_vid[$];
    logic [23:0] exp_aux[$];
    logic [7:0]  frm[$];
    logic [34:0] ev;
    logic [23:0] ea;

    always @(negedge clk125) begin
        if (vid_wr_en) begin
            vid_seen++;
            compared++;
            if (exp_vid.size() == 0) begin
                mismatched++;
                $display("FAIL vid_unexpected: got %h want none", {vid_sof, vid_data});
            end else begin
                ev = exp_vid.pop_front();
                if ({vid_sof, vid_data} !== ev) begin
                    mismatched++;
                    $display("FAIL vid_word#%0d: got %h want %h", vid_seen, {vid_sof, vid_data}, ev);
                end
            end
        end
        if (aux_wr_en) begin
            aux_seen++;
            compared++;
            if (exp_aux.size() == 0) begin
                mismatched++;
                $display("FAIL aux_unexpected: got %h want none", aux_data);
            end else begin
                ea = exp_aux.pop_front();
                if (aux_data !== ea) begin
                    mismatched++;
                    $display("FAIL aux_word#%0d: got %h want %h", aux_seen, aux_data, ea);
                end
            end
        end
        if (vid_abort) abort_seen++;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] pbyte(input int j, input int s);
        return 8'(j * 7 + s);
    endfunction

    task automatic build(input logic [7:0] ip_last, input logic [15:0] port,
                         input logic [7:0] typ, input logic [11:0] y, input logic [3:0] x);
        logic [7:0] h [0:29];
        h = '{8'h08, 8'h00, 8'h45, 8'h00, 8'h04, 8'hD2, 8'h00, 8'h01, 8'h40, 8'h00,
              8'h40, 8'h11, 8'h00, 8'h00, 8'hC0, 8'hA8, 8'h00, 8'h0A, 8'hC0, 8'hA8,
              8'h00, ip_last, 8'h13, 8'h88, port[15:8], port[7:0], 8'h04, 8'hBE, 8'h00, 8'h00};
        frm.delete();
        repeat (7) frm.push_back(8'h55);
        frm.push_back(8'hD5);
        repeat (6) frm.push_back(8'hFF);
        for (int i = 0; i < 6; i++) frm.push_back(8'(i + 2));
        for (int i = 0; i < 30; i++) frm.push_back(h[i]);
        frm.push_back(typ);
        if (typ != 8'h01) begin
            frm.push_back(y[7:0]);
            frm.push_back({x, y[11:8]});
        end
    endtask

    task automatic add_video(input logic [1:0] ch, input logic [11:0] y, input logic [3:0] x,
                             input int n_exp, input int s);
        for (int j = 0; j < 1200; j++) frm.push_back(pbyte(j, s));
        for (int k = 0; k < n_exp; k++)
            exp_vid.push_back({(k == 0), ch, y, x, pbyte(2 * k, s), pbyte(2 * k + 1, s)});
    endtask

    task automatic add_aux(input logic [11:0] id, input logic [3:0] left, input int s);
        logic [7:0] d;
        frm.push_back(id[7:0]);
        frm.push_back({left, id[11:8]});
        for (int j = 0; j < 32; j++) begin
            d = 8'(j * 5 + s);
            frm.push_back(d);
            exp_aux.push_back({id, 4'h0, d});
        end
    endtask

    task automatic add_fcs();
        frm.push_back(8'hDE); frm.push_back(8'hAD); frm.push_back(8'hBE); frm.push_back(8'hEF);
    endtask

    task automatic snap();
        v0 = vid_seen; a0 = aux_seen; ab0 = abort_seen;
    endtask

    // mode 0: whole frame; 1: rx_dv drops before byte stop; 2: rx_er on byte stop;
    // 3: asynchronous reset pulse at byte stop
    task automatic drive(input int mode, input int stop);
        for (int i = 0; i < frm.size(); i++) begin
            if (!(mode == 1 && i >= stop)) begin
                @(negedge clk125);
                if (mode == 3 && i == stop) begin
                    #2 sys_rst_n = 1'b0;
                    #1;
                    chk("arst_vid_wr_en", 64'(vid_wr_en), 0);
                    chk("arst_vid_sof", 64'(vid_sof), 0);
                    chk("arst_vid_data", 64'(vid_data), 0);
                    chk("arst_aux_data", 64'(aux_data), 0);
                    chk("arst_ok_cnt", 64'(pkt_ok_cnt), 0);
                    chk("arst_drop_cnt", 64'(pkt_drop_cnt), 0);
                end
                if (mode == 3 && i == stop + 2) sys_rst_n = 1'b1;
                rx_dv = 1'b1;
                rxd   = frm[i];
                rx_er = (mode == 2 && i == stop);
            end
        end
        @(negedge clk125);
        rx_dv = 1'b0; rx_er = 1'b0; rxd = 8'h00;
        repeat (12) @(negedge clk125);
    endtask

    task automatic check_frame(input string tag, input int dv, input int da, input int dab,
                               input int ok, input int drop);
        chk({tag, "_vid_writes"}, 64'(vid_seen - v0), 64'(dv));
        chk({tag, "_aux_writes"}, 64'(aux_seen - a0), 64'(da));
        if (dab >= 0) chk({tag, "_aborts"}, 64'(abort_seen - ab0), 64'(dab));
        chk({tag, "_ok_cnt"}, 64'(pkt_ok_cnt), 64'(ok));
        chk({tag, "_drop_cnt"}, 64'(pkt_drop_cnt), 64'(drop));
        chk({tag, "_vid_q_left"}, 64'(exp_vid.size()), 0);
        chk({tag, "_aux_q_left"}, 64'(exp_aux.size()), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk125);
        chk("rst_vid_wr_en", 64'(vid_wr_en), 0);
        chk("rst_vid_sof", 64'(vid_sof), 0);
        chk("rst_vid_abort", 64'(vid_abort), 0);
        chk("rst_vid_data", 64'(vid_data), 0);
        chk("rst_aux_wr_en", 64'(aux_wr_en), 0);
        chk("rst_aux_data", 64'(aux_data), 0);
        chk("rst_ok_cnt", 64'(pkt_ok_cnt), 0);
        chk("rst_drop_cnt", 64'(pkt_drop_cnt), 0);
        sys_rst_n = 1'b1;
        repeat (4) @(negedge clk125);

        snap(); build(8'h01, 16'd12345, 8'h00, 12'h123, 4'h5);
        add_video(2'd0, 12'h123, 4'h5, 600, 3); add_fcs(); drive(0, 0);
        check_frame("vid_ch0", 600, 0, 0, 1, 0);

        snap(); build(8'h02, 16'd12345, 8'h00, 12'h456, 4'hA);
        add_video(2'd1, 12'h456, 4'hA, 600, 11); add_fcs(); drive(0, 0);
        check_frame("vid_ch1", 600, 0, 0, 2, 0);

        snap(); build(8'h03, 16'd12345, 8'h00, 12'h001, 4'h1);
        add_video(2'd2, 12'h001, 4'h1, 0, 5); add_fcs(); drive(0, 0);
        check_frame("ip_base2", 0, 0, 0, 2, 0);

        snap(); build(8'h01, 16'd12346, 8'h00, 12'h001, 4'h1);
        add_video(2'd0, 12'h001, 4'h1, 0, 5); add_fcs(); drive(0, 0);
        check_frame("bad_port", 0, 0, 0, 2, 0);

        snap(); build(8'h01, 16'd12345, 8'h02, 12'hFFF, 4'h0);
        add_video(2'd0, 12'hFFF, 4'h0, 600, 29);
        add_aux(12'h0A5, 4'd2, 17); add_aux(12'h0A6, 4'd2, 90); add_fcs(); drive(0, 0);
        check_frame("vid_aux", 600, 64, 0, 3, 0);

        snap(); build(8'h02, 16'd12345, 8'h00, 12'h007, 4'hF);
        add_video(2'd1, 12'h007, 4'hF, 50, 41); add_fcs(); drive(1, 8 + 45 + 101);
        check_frame("dv_drop", 50, 0, 1, 3, 1);

        snap(); build(8'h01, 16'd12345, 8'h00, 12'h800, 4'h3);
        add_video(2'd0, 12'h800, 4'h3, 600, 77); add_fcs(); drive(0, 0);
        check_frame("after_drop", 600, 0, 0, 4, 1);

        snap(); build(8'h01, 16'd12345, 8'h00, 12'h222, 4'h2);
        add_video(2'd0, 12'h222, 4'h2, 7, 9); add_fcs(); drive(2, 8 + 60);
        check_frame("rx_er_b60", 7, 0, 1, 4, 2);

        snap(); build(8'h01, 16'd12345, 8'h07, 12'h222, 4'h2);
        add_video(2'd0, 12'h222, 4'h2, 0, 9); add_fcs(); drive(0, 0);
        check_frame("bad_type", 0, 0, -1, 4, 3);

        snap(); build(8'h01, 16'd12345, 8'h00, 12'h345, 4'h6);
        add_video(2'd0, 12'h345, 4'h6, 600, 55); add_fcs(); drive(2, 8 + 1244);
        check_frame("er_last_byte", 600, 0, 0, 5, 3);

        snap(); build(8'h01, 16'd12345, 8'h01, 12'h000, 4'h0);
        frm.push_back(8'h34); frm.push_back(8'h01); add_fcs(); drive(0, 0);
        check_frame("aux_left0", 0, 0, 0, 6, 3);

        snap(); build(8'h01, 16'd12345, 8'h00, 12'h0C3, 4'h9);
        add_video(2'd0, 12'h0C3, 4'h9, 10, 63); add_fcs(); drive(3, 8 + 65);
        check_frame("arst_mid_vid", 10, 0, 0, 0, 0);

        snap(); build(8'h02, 16'd12345, 8'h00, 12'hABC, 4'h4);
        add_video(2'd1, 12'hABC, 4'h4, 600, 101); add_fcs(); drive(0, 0);
        check_frame("after_arst", 600, 0, 0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
